hub75_scan_ctrl: RTL and testbench

//  Binary-code-modulation (BCM) scan sequencer sitting directly upstream of hub75_fetchshift.

---
 rtl/hub75_scan_ctrl.sv | 115 +++++++++++
 tb/tb_hub75_scan_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_scan_ctrl.sv
// BCM scan sequencer for a HUB75 panel: hands (row, bit-plane) shift jobs to fetchshift and
// drives row address, latch and output-enable so the next plane shifts while the current one shows.
module hub75_scan_ctrl #(
   parameter int SCAN_ROWS   = 32,
   parameter int ADDR_W      = 5,
   parameter int BIT_PLANES  = 8,
   parameter int BASE_TICKS  = 4,
   parameter int DEAD_CYCLES = 2,
   parameter int TIMER_W     = 16
) (
   input  logic              sys_clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              busy,
   output logic              start,
   output logic [2:0]        bit_cnt,
   output logic [5:0]        row_cnt,
   output logic [ADDR_W-1:0] row_addr,
   output logic              lat,
   output logic              oe_n,
   output logic              frame_done
);

   typedef enum logic [2:0] {
      IDLE, KICK, WAIT_BH, WAIT_BL, WAIT_DISP, BLANK, LATCH, UNBLANK
   } state_t;

   localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
   localparam logic [DEAD_W-1:0] LAST_DEAD = DEAD_W'(DEAD_CYCLES - 1);
   localparam logic [2:0]        LAST_BIT  = 3'(BIT_PLANES - 1);
   localparam logic [5:0]        LAST_ROW  = 6'(SCAN_ROWS - 1);

   state_t              state;
   logic [TIMER_W-1:0]  timer;
   logic [2:0]          disp_bit;
   logic [DEAD_W-1:0]   dead_cnt;

   // NOTE: every register here is assigned with <= so all of them see the pre-edge values.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         start      <= 1'b0;
         bit_cnt    <= '0;
         row_cnt    <= '0;
         row_addr   <= '0;
         lat        <= 1'b0;
         oe_n       <= 1'b1;
         frame_done <= 1'b0;
         timer      <= '0;
         disp_bit   <= '0;
         dead_cnt   <= '0;
      end else begin
         start      <= 1'b0;
         lat        <= 1'b0;
         frame_done <= 1'b0;
         if (timer != '0)
            timer <= timer - 1'b1;
         // oe_n tracks the timer's next value, so it is low exactly while timer != 0.
         oe_n <= (timer <= TIMER_W'(1));

         case (state)
            IDLE: begin
               if (enable) begin
                  state <= KICK;
                  start <= 1'b1;
               end
            end
            KICK:    state <= WAIT_BH;
            WAIT_BH: if (busy)  state <= WAIT_BL;
            WAIT_BL: if (!busy) state <= WAIT_DISP;
            WAIT_DISP: begin
               if (timer == '0) begin
                  state    <= BLANK;
                  dead_cnt <= '0;
               end
            end
            BLANK: begin
               if (dead_cnt == LAST_DEAD) begin
                  state    <= LATCH;
                  lat      <= 1'b1;
                  row_addr <= row_cnt[ADDR_W-1:0];
                  disp_bit <= bit_cnt;
               end else begin
                  dead_cnt <= dead_cnt + 1'b1;
               end
            end
            LATCH:   state <= UNBLANK;
            UNBLANK: begin
               timer <= TIMER_W'(BASE_TICKS) << disp_bit;
               oe_n  <= 1'b0;
               if (bit_cnt == LAST_BIT) begin
                  bit_cnt <= '0;
                  if (row_cnt == LAST_ROW) begin
                     row_cnt    <= '0;
                     frame_done <= 1'b1;
                  end else begin
                     row_cnt <= row_cnt + 1'b1;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
               // With enable low the plane just latched still displays; no further shift is started.
               if (enable) begin
                  state <= KICK;
                  start <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Scoreboard bench for hub75_scan_ctrl: expected shift pointers are queued by the driver and a
// negedge monitor checks start, latch timing, row address, BCM run lengths and frame_done.
module tb_hub75_scan_ctrl;

   localparam int ROWS   = 32;
   localparam int PLANES = 8;
   localparam int BASE   = 4;
   localparam int DEAD   = 2;

   logic       sys_clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       busy;
   logic       start;
   logic [2:0] bit_cnt;
   logic [5:0] row_cnt;
   logic [4:0] row_addr;
   logic       lat;
   logic       oe_n;
   logic       frame_done;

   hub75_scan_ctrl dut (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .busy       (busy),
      .start      (start),
      .bit_cnt    (bit_cnt),
      .row_cnt    (row_cnt),
      .row_addr   (row_addr),
      .lat        (lat),
      .oe_n       (oe_n),
      .frame_done (frame_done)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      int bitp;
      int row;
   } plane_t;

   plane_t exp_q[$];

   // Reference pointer order: plane index k walks bit-planes within a row, rows within a frame.
   function automatic plane_t plane_of(input int k);
      plane_t p;
      p.bitp = k % PLANES;
      p.row  = (k / PLANES) % ROWS;
      return p;
   endfunction

   task automatic push_planes(input int first, input int n);
      for (int i = 0; i < n; i++)
         exp_q.push_back(plane_of(first + i));
   endtask

   int     starts_seen = 0;
   bit     mon_en      = 1'b0;
   int     busy_fall   = 0;
   int     fd_count    = 0;
   plane_t last_started = '{bitp: 0, row: 0};

   // Fetchshift stand-in: busy high for n cycles starting the cycle after start.
   initial begin
      int resp_cnt;
      int n;
      int b;
      resp_cnt = 0;
      busy = 1'b0;
      forever begin
         @(negedge sys_clk);
         if (start) begin
            b = int'(bit_cnt);
            if (resp_cnt < 8)
               n = 10;
            else if (b == 0)
               n = 5;
            else
               n = int'($urandom_range(1, 24));
            resp_cnt++;
            busy_fall = cyc + n + 1;
            @(posedge sys_clk);
            #1 busy = 1'b1;
            repeat (n) @(posedge sys_clk);
            #1 busy = 1'b0;
         end
      end
   end

   // Monitor: compares DUT activity against queued expectations and timing rules.
   initial begin
      plane_t     e;
      int         oe_high;
      int         run_len;
      int         exp_run;
      int         oe_rise;
      int         exp_lat;
      bit         run_pending;
      bit         exp_fd;
      logic       prev_oe;
      logic [5:0] prev_row;
      logic [4:0] prev_addr;
      oe_high = 0; run_len = 0; exp_run = 0; oe_rise = 0; run_pending = 1'b0;
      prev_oe = 1'b1; prev_row = '0; prev_addr = '0;
      forever begin
         @(negedge sys_clk);
         if (mon_en) begin
            if (start) begin
               check("start_busy", 32'(busy), 0);
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_start: got bit=%0d row=%0d expected no start (cycle %0d)",
                           bit_cnt, row_cnt, cyc);
               end else begin
                  e = exp_q.pop_front();
                  check("start_bit", 32'(bit_cnt), e.bitp);
                  check("start_row", 32'(row_cnt), e.row);
                  last_started = e;
               end
               starts_seen++;
            end

            if (lat) begin
               check("lat_oe_n", 32'(oe_n), 1);
               check("dead_cycles", 32'(oe_high >= DEAD), 1);
               check("row_addr", 32'(row_addr), last_started.row);
               exp_lat = (busy_fall + 4 > oe_rise + 3) ? busy_fall + 4 : oe_rise + 3;
               check("lat_time", cyc, exp_lat);
               exp_run     = BASE << last_started.bitp;
               run_pending = 1'b1;
            end else if (row_addr !== prev_addr) begin
               check("row_addr_hold", 32'(row_addr), 32'(prev_addr));
            end

            if (!oe_n) begin
               if (prev_oe) begin
                  check("oe_after_lat", 32'(run_pending), 1);
                  run_pending = 1'b0;
                  run_len     = 0;
               end
               run_len++;
               oe_high = 0;
            end else begin
               if (!prev_oe) begin
                  check("oe_run", run_len, exp_run);
                  oe_rise = cyc;
               end
               oe_high++;
            end

            exp_fd = (prev_row == 6'(ROWS - 1)) && (row_cnt == '0);
            if (exp_fd || frame_done)
               check("frame_done", 32'(frame_done), 32'(exp_fd));
            if (frame_done)
               fd_count++;
         end
         prev_row  = row_cnt;
         prev_addr = row_addr;
         prev_oe   = oe_n;
      end
   end

   task automatic wait_starts(input int target, input int budget);
      int n;
      n = 0;
      while (starts_seen < target && n < budget) begin
         @(negedge sys_clk);
         #1;
         n++;
      end
      check("start_count", starts_seen, target);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_start"},      32'(start), 0);
      check({tag, "_lat"},        32'(lat), 0);
      check({tag, "_oe_n"},       32'(oe_n), 1);
      check({tag, "_bit_cnt"},    32'(bit_cnt), 0);
      check({tag, "_row_cnt"},    32'(row_cnt), 0);
      check({tag, "_row_addr"},   32'(row_addr), 0);
      check({tag, "_frame_done"}, 32'(frame_done), 0);
   endtask

   initial begin
      rst_n  = 1'b0;
      enable = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1 check_reset("reset");
      rst_n = 1'b1;
      @(posedge sys_clk);
      #1;

      // Full frame plus four planes; enable drops once plane 3 of the new frame starts shifting.
      push_planes(0, 260);
      mon_en = 1'b1;
      enable = 1'b1;
      wait_starts(260, 80000);
      enable = 1'b0;

      repeat (300) @(negedge sys_clk);
      #1;
      check("idle_oe_n", 32'(oe_n), 1);
      check("idle_starts", starts_seen, 260);
      check("idle_queue", exp_q.size(), 0);

      // Re-enable resumes at the plane after the one that was latched.
      push_planes(260, 12);
      enable = 1'b1;
      wait_starts(272, 8000);
      repeat (2) @(negedge sys_clk);
      check("pre_reset_oe_n", 32'(oe_n), 0);
      check("frame_done_count", fd_count, 1);

      mon_en = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_reset("mid_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
